// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator: 640x480@60 defaults,
// line/frame totals and the sync/display bundle carried through the delay line.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  typedef struct packed {
    logic disp;
    logic hsync;
    logic vsync;
  } vga_sig_t;

  function automatic int h_total(int active, int front, int sync, int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(int active, int front, int sync, int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
// Reset loads every stage with rst_val_i so idle stages look like "blank, syncs inactive".
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, ena_i, rst_val_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= rst_val_i;
      end else if (ena_i) begin
        stage_q[0] <= d_i;
        for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with sync/display decode; sync and display_on are re-timed
// by OUT_DELAY ena-cycles to line up with a pipelined colour path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_ACT = SYNC_ACT_LOW,
  parameter bit VSYNC_ACT = SYNC_ACT_LOW,
  parameter int COORD_W   = 10,
  parameter int FRAME_W   = 8,
  parameter int OUT_DELAY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (OUT_DELAY < 0 || OUT_DELAY > 3) begin : g_bad_delay
    $error("vga_timing_gen: OUT_DELAY must be 0..3");
  end
  if (COORD_W < 1 || COORD_W > 30 || (H_TOT - 1) >= (2 ** COORD_W) ||
      (V_TOT - 1) >= (2 ** COORD_W)) begin : g_bad_coord
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] hpos_q, hpos_d;
  logic [COORD_W-1:0] vpos_q, vpos_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    fcnt_d = fcnt_q;
    if (ena) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
          fcnt_d = fcnt_q + 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q <= '0;
      vpos_q <= '0;
      fcnt_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      fcnt_q <= fcnt_d;
    end
  end

  vga_sig_t sig_raw, sig_idle, sig_out;
  logic     hs_win, vs_win;

  assign hs_win        = (hpos_q >= HS_LO) && (hpos_q < HS_HI);
  assign vs_win        = (vpos_q >= VS_LO) && (vpos_q < VS_HI);
  assign sig_raw.disp  = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  assign sig_raw.hsync = hs_win ? HSYNC_ACT : ~HSYNC_ACT;
  assign sig_raw.vsync = vs_win ? VSYNC_ACT : ~VSYNC_ACT;

  // Value the delay stages hold out of reset: blanked, both syncs inactive.
  assign sig_idle.disp  = 1'b0;
  assign sig_idle.hsync = ~HSYNC_ACT;
  assign sig_idle.vsync = ~VSYNC_ACT;

  vga_delay_line #(
    .DEPTH (OUT_DELAY),
    .WIDTH ($bits(vga_sig_t))
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .ena_i     (ena),
    .rst_val_i (sig_idle),
    .d_i       (sig_raw),
    .q_o       (sig_out)
  );

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_cnt   = fcnt_q;
  assign display_on  = sig_out.disp;
  assign hsync       = sig_out.hsync;
  assign vsync       = sig_out.vsync;
  assign line_start  = ena && (hpos_q == '0);
  assign frame_start = line_start && (vpos_q == '0);

endmodule
